// File: rtl/fft_frame_loader_if.sv
// -----------------------------------------------------------------------------
// fft_frame_loader_if
//
// Streaming sample handshake into the FFT frame loader: one complex sample per
// valid/ready transfer plus an optional end-of-frame marker.
//
// Signals:
//   in_valid  upstream has a sample on in_real/in_im/in_last
//   in_ready  loader can accept a sample this cycle
//   in_real   sample real part, signed Q8.8 at W=16
//   in_im     sample imaginary part, signed
//   in_last   marks the final sample of a frame
//
// Modports:
//   master  upstream source (drives valid/data/last, observes ready)
//   slave   the loader (observes valid/data/last, drives ready)
//
// W must match the W parameter of the loader it connects to.
// -----------------------------------------------------------------------------
interface fft_frame_loader_if #(
   parameter int W = 16
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_real;
   logic signed [W-1:0] in_im;
   logic                in_last;

   modport master (
      output in_valid,
      output in_real,
      output in_im,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_real,
      input  in_im,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Streaming-to-parallel frame assembler feeding a parallel FFT core. Samples
// arrive one per handshake in natural order and are collected into a write
// buffer. A complete frame is copied into the x_real/x_im output registers,
// which then stay unchanged for at least HOLD cycles so the downstream
// registered butterflies see one coherent frame.
//
// Parameters:
//   N       frame length (power of 2, same as the FFT core)
//   W       sample width (signed)
//   STAGES  log2(N); width of the write index
//   HOLD    minimum number of cycles an output frame is held (>= 1)
//   CW      frame counter width
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   s_in         sample stream (slave side of fft_frame_loader_if)
//   x_real       frame real parts, natural order
//   x_im         frame imaginary parts, natural order
//   frame_valid  one-cycle pulse in the first cycle a new frame is on x_*
//   frame_count  number of frames transferred, wraps modulo 2**CW
//   err_frame    one-cycle pulse when a frame is dropped on an early in_last
// -----------------------------------------------------------------------------
module fft_frame_loader #(
   parameter int N      = 16,
   parameter int W      = 16,
   parameter int STAGES = 4,
   parameter int HOLD   = STAGES + 1,
   parameter int CW     = 16
) (
   input  logic                clk,
   input  logic                rst,
   fft_frame_loader_if.slave   s_in,
   output logic signed [W-1:0] x_real [0:N-1],
   output logic signed [W-1:0] x_im   [0:N-1],
   output logic                frame_valid,
   output logic [CW-1:0]       frame_count,
   output logic                err_frame
);

   localparam int IW = (STAGES > 0) ? STAGES : 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,   // accepting samples
      S_FULL = 1'b1    // buffer complete, waiting for the hold window
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [IW-1:0]   wr_idx_reg;
   logic [IW-1:0]   wr_idx_next;
   logic [HW-1:0]   hold_reg;
   logic [HW-1:0]   hold_next;
   logic [CW-1:0]   frame_count_reg;
   logic            frame_valid_reg;
   logic            err_frame_reg;

   logic            ready;
   logic            wr_en;
   logic            transfer;
   logic            bypass;
   logic            err_next;

   logic signed [W-1:0] wbuf_real  [0:N-1];
   logic signed [W-1:0] wbuf_im    [0:N-1];
   logic signed [W-1:0] x_real_reg [0:N-1];
   logic signed [W-1:0] x_im_reg   [0:N-1];
   logic signed [W-1:0] src_real   [0:N-1];
   logic signed [W-1:0] src_im     [0:N-1];

   // -------------------------------------------------------------------------
   // Control FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_FILL;
         wr_idx_reg      <= '0;
         hold_reg        <= '0;
         frame_count_reg <= '0;
         frame_valid_reg <= 1'b0;
         err_frame_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wr_idx_reg      <= wr_idx_next;
         hold_reg        <= hold_next;
         frame_valid_reg <= transfer;
         err_frame_reg   <= err_next;
         if (transfer) begin
            frame_count_reg <= frame_count_reg + CW'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM: next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      wr_idx_next = wr_idx_reg;
      // Hold window counts down and rests at zero.
      hold_next   = (hold_reg != '0) ? (hold_reg - HW'(1)) : '0;
      ready       = 1'b0;
      wr_en       = 1'b0;
      transfer    = 1'b0;
      bypass      = 1'b0;
      err_next    = 1'b0;

      case (state_reg)
         S_FILL: begin
            // Ready is forced low while reset is held so nothing is taken.
            ready = !rst;
            if (s_in.in_valid && !rst) begin
               wr_en = 1'b1;
               if (wr_idx_reg == LAST_IDX) begin
                  // Completion is by count; in_last here is just the normal
                  // end marker and a missing one is not an error.
                  wr_idx_next = '0;
                  if (hold_reg == '0) begin
                     // Last sample goes straight to the output registers,
                     // it is not yet in the write buffer on this edge.
                     transfer = 1'b1;
                     bypass   = 1'b1;
                  end else begin
                     state_next = S_FULL;
                  end
               end else if (s_in.in_last) begin
                  // Early end marker: drop the partial frame.
                  wr_idx_next = '0;
                  err_next    = 1'b1;
               end else begin
                  wr_idx_next = wr_idx_reg + IW'(1);
               end
            end
         end
         S_FULL: begin
            if (hold_reg == '0) begin
               transfer   = 1'b1;
               state_next = S_FILL;
            end
         end
         default: begin
            state_next = S_FILL;
         end
      endcase

      if (transfer) begin
         hold_next = HOLD_INIT;
      end
   end

   assign s_in.in_ready = ready;

   // -------------------------------------------------------------------------
   // Write buffer (data only, contents after reset are don't-care)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         wbuf_real[wr_idx_reg] <= s_in.in_real;
         wbuf_im[wr_idx_reg]   <= s_in.in_im;
      end
   end

   // -------------------------------------------------------------------------
   // Transfer sources: only the last element can come from the bypass path
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < N; gi++) begin : g_elem
      if (gi == N - 1) begin : g_bypass
         assign src_real[gi] = bypass ? s_in.in_real : wbuf_real[gi];
         assign src_im[gi]   = bypass ? s_in.in_im   : wbuf_im[gi];
      end else begin : g_buf
         assign src_real[gi] = wbuf_real[gi];
         assign src_im[gi]   = wbuf_im[gi];
      end
      assign x_real[gi] = x_real_reg[gi];
      assign x_im[gi]   = x_im_reg[gi];
   end

   // -------------------------------------------------------------------------
   // Output frame registers: change only on a transfer edge
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            x_real_reg[i] <= '0;
            x_im_reg[i]   <= '0;
         end
      end else if (transfer) begin
         for (int i = 0; i < N; i++) begin
            x_real_reg[i] <= src_real[i];
            x_im_reg[i]   <= src_im[i];
         end
      end
   end

   assign frame_valid = frame_valid_reg;
   assign frame_count = frame_count_reg;
   assign err_frame   = err_frame_reg;

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Streaming-to-parallel frame assembler placed directly upstream of the parallel `fft` core. It accepts one complex sample per handshake and collects N samples into a write buffer. It then transfers the complete frame into output registers that drive the core's `x_real`/`x_im` arrays. The output frame is held stable for at least HOLD cycles so the registered butterfly stages can settle on one frame.

## Interface

Parameters:

- `N`, default 16: frame length. Power of 2, same value as the `fft` core.
- `W`, default 16: sample width, signed Q8.8.
- `STAGES`, default 4: log2(N).
- `HOLD`, default STAGES+1: minimum cycles an output frame stays unchanged. Must be ≥1.
- `CW`, default 16: frame counter width.

Ports (one clock; reset is synchronous and active-high):

- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: loader can accept a sample.
- `in_real`, in, W signed: sample real part.
- `in_im`, in, W signed: sample imaginary part.
- `in_last`, in, 1: marks the final sample of a frame. Optional alignment check.
- `x_real`, out, W signed × [0:N-1]: frame real parts, natural order. Connects to `fft.x_real`.
- `x_im`, out, W signed × [0:N-1]: frame imaginary parts, natural order.
- `frame_valid`, out, 1: one-cycle pulse in the first cycle a new frame is on `x_*`.
- `frame_count`, out, CW: number of frames transferred. Wraps modulo 2^CW.
- `err_frame`, out, 1: one-cycle pulse when a frame is dropped because `in_last` arrived early.

## Operation

- **Accept.** A sample is accepted on an edge where `in_valid && in_ready`. Accepted samples are written into `wbuf[wr_idx]`, then `wr_idx` increments. `wr_idx` is log2(N) bits, starting at 0.
- **Input order.** Samples are in natural order; bit reversal stays inside `fft`.
- **States:**
  - FILL: `in_ready`=1.
  - FULL: `in_ready`=0. The write buffer is complete and waiting for the hold window to expire.
- **`hold_cnt`.** Counts down from HOLD-1 to 0 after each transfer and saturates at 0.
- **Transfer.** The frame is loaded into `x_real`/`x_im`.
  - In FILL, accepting index N-1 with `hold_cnt`==0: transfer on that same edge. The incoming sample bypasses into element N-1. `wr_idx`←0 and the state remains FILL.
  - In FILL, accepting index N-1 with `hold_cnt`≠0: go to FULL with no transfer.
  - In FULL: transfer on the edge where `hold_cnt`==0, then return to FILL with `wr_idx`=0.
- **On every transfer:** `hold_cnt`←HOLD-1, `frame_valid`←1 for the next cycle, `frame_count`←`frame_count`+1.
- **Early `in_last`.** If `in_last` is accepted at index < N-1, the partial frame is discarded. `wr_idx`←0, `err_frame` pulses the next cycle, and `x_*` are unchanged.
- **Missing `in_last`.** If `in_last`=0 at index N-1, the frame is still transferred normally with no error. Frame boundaries are defined by count.
- **Stability.** `x_*` change only on transfer edges. No arithmetic is performed; data passes bit-exact.

## Timing

- **Reset values.** While `rst`=1 at an edge:
  - Data: `x_real`, `x_im` all 0.
  - Status: `frame_valid`=0, `err_frame`=0, `frame_count`=0.
  - Control: `wr_idx`=0, `hold_cnt`=0, state FILL.
  - `in_ready` is 0 combinationally during reset and 1 in the first cycle after reset deasserts.
- **Reset mid-frame.** Partial write-buffer contents are abandoned. The next accepted sample is index 0.
- **Latency.** Sample N-1 accepted at edge E (no stall): `x_*` carry the new frame and `frame_valid`=1 in the cycle after E.
  - Downstream `fft` adds its own STAGES-cycle pipeline latency.
- **Minimum frame period.** N cycles when N ≥ HOLD. This gives zero stall at the defaults.
- **Stall case.** With HOLD > N, the loader enters FULL and `in_ready` drops for HOLD-N cycles per frame.
- **Input handshake.** `in_real`/`in_im`/`in_last` are ignored when `in_valid`=0 or `in_ready`=0. Upstream must hold data while `in_valid` is high and `in_ready` is low.
- **Simultaneous events.** When `in_last` and index N-1 coincide, this is a normal completion; `err_frame` is never raised at index N-1.
- **Back-to-back frames.** Accepting index 0 of the next frame on the edge right after a transfer is legal.
- **`frame_count` wrap.** 2^CW-1 → 0 with no flag.

## Test plan

- **Reset.** Assert `rst` for 3 cycles with `in_valid`=1 → all `x_*`=0, `frame_valid`=0, `frame_count`=0, `in_ready`=0 during reset. After release, `in_ready`=1 and nothing is accepted during reset.
- **Single frame, defaults.** Stream samples `in_real`=k·256, `in_im`=-k for k=0..15, `in_last` on k=15 → exactly one `frame_valid` pulse the cycle after sample 15. `x_real[k]`=k·256, `x_im[k]`=-k, `frame_count`=1.
- **Continuous streaming.** 4 frames back-to-back with no idle → `in_ready` stays 1, `frame_valid` pulses every 16 cycles, `frame_count`=4. Each frame is held unchanged for 16 cycles.
- **Stall.** HOLD=24, two back-to-back frames → after the second frame's sample 15, `in_ready`=0 for 8 cycles. The transfer occurs exactly 24 cycles after the first, and no samples are lost.
- **Early `in_last`.** `in_last` at index 9 → `err_frame` pulses once, `x_*` and `frame_count` unchanged. The next 16 samples form a valid frame.
- **Backpressure and mid-frame reset.** Random `in_valid` gaps produce a correct frame. Reset asserted after 7 samples, then 16 new samples → only the new samples appear and `frame_count`=1.
